// File: rtl/clock_step_gate_pkg.sv
// Shared mode encodings and channel FSM states for the multi-channel clock step gate.
package clock_step_gate_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } chan_state_t;

endpackage

// File: rtl/clock_step_gate_chan.sv
// One gated-clock channel: request FSM, pulse counter, posedge enable, low-transparent latch, AND gate.
//
// state     | meaning
// ST_IDLE   | waiting; OFF/RUN gating handled here, STEP/BURST requests accepted here
// ST_ACTIVE | accepted STEP/BURST in progress; mode and req ignored until done
module clock_step_gate_chan
    import clock_step_gate_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             req,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             hold,
    output logic             gclk,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    chan_state_t state;
    logic        gate_en;
    logic        gate_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            gate_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    case (mode)
                        MODE_OFF: gate_en <= 1'b0;
                        MODE_RUN: gate_en <= req & ~hold;
                        MODE_STEP: begin
                            gate_en <= 1'b0;
                            if (req) begin
                                remaining <= CNT_W'(1);
                                gate_en   <= ~hold;
                                busy      <= 1'b1;
                                state     <= ST_ACTIVE;
                            end
                        end
                        MODE_BURST: begin
                            gate_en <= 1'b0;
                            if (req) begin
                                // A zero-length burst passes through ACTIVE only to delay done by one cycle.
                                remaining <= burst_len;
                                gate_en   <= (burst_len != '0) & ~hold;
                                busy      <= (burst_len != '0);
                                state     <= ST_ACTIVE;
                            end
                        end
                    endcase
                end
                ST_ACTIVE: begin
                    if (gate_en) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            gate_en <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            gate_en <= ~hold;
                        end
                    end else if (remaining == '0) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        gate_en <= ~hold;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Latch only opens while clk is low, so gate_en changes never reach gclk mid-high-phase.
    always_latch begin
        if (rst)
            gate_q <= 1'b0;
        else if (!clk)
            gate_q <= gate_en;
    end

    assign gclk = clk & gate_q;

endmodule

// File: rtl/clock_step_gate.sv
// Multi-channel glitch-free gated-clock generator; one independent channel per output.
module clock_step_gate
    import clock_step_gate_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CNT_W*CHANNELS-1:0] burst_len,
    input  logic                      hold,
    output logic [CHANNELS-1:0]       gclk,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done,
    output logic [CNT_W*CHANNELS-1:0] remaining
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clock_step_gate_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .mode     (mode[2*i +: 2]),
            .req      (req[i]),
            .burst_len(burst_len[CNT_W*i +: CNT_W]),
            .hold     (hold),
            .gclk     (gclk[i]),
            .busy     (busy[i]),
            .done     (done[i]),
            .remaining(remaining[CNT_W*i +: CNT_W])
        );
    end

endmodule

// File: doc/clock_step_gate.md
Name: clock_step_gate

Overview:
- Multi-channel, glitch-free gated-clock generator with per-channel modes: off, free-run, single-step and N-pulse burst.
- Successor to the single-channel positive-edge gate. Adds a channel count, a programmable burst length, a req/busy/done handshake and a global hold.
- Sits between the system clock and the clock inputs of the simulated datapath sections. The debug controller uses it to free-run, single-step or burst-step each section independently.

Parameters:
CHANNELS, 4, number of independent gated-clock outputs
CNT_W, 8, width of the burst length and remaining-pulse counter

Ports:
clk  input  1  system clock; the source of every gated edge
rst  input  1  asynchronous, active-high reset
mode  input  2*CHANNELS  per-channel mode, channel i at bits [2i+1:2i]: 00 OFF, 01 RUN, 10 STEP, 11 BURST
req  input  CHANNELS  RUN: level enable. STEP/BURST: request, sampled at posedge
burst_len  input  CNT_W*CHANNELS  per-channel burst length, sampled at request accept
hold  input  1  global pause; suppresses edges without losing pending counts
gclk  output  CHANNELS  gated clock outputs
busy  output  CHANNELS  channel has an accepted STEP/BURST in progress
done  output  CHANNELS  one-cycle pulse when a STEP/BURST completes
remaining  output  CNT_W*CHANNELS  pulses still to be issued for the current burst

Behaviour:
- Reset, asynchronous: gate_en, busy, done and remaining go to 0 for all channels. The gating latch is forced closed, so gclk goes low immediately, even mid-high-phase.
- Gating structure, per channel:
  - gate_en is a posedge register.
  - gate_q is a latch, transparent while clk is low, that captures gate_en.
  - gclk = clk AND gate_q.
  - gclk never glitches and never produces a partial high phase.
- Timing rule: gate_en = 1 after posedge k means gclk pulses high during the high phase beginning at posedge k+1.
- Mode and burst_len are sampled only when a request is accepted in IDLE. Changes while busy are ignored until the channel returns to IDLE.
- Per-channel FSM: IDLE, ACTIVE.
  - IDLE, mode OFF: gate_en = 0; req ignored.
  - IDLE, mode RUN: gate_en <= req[i] & ~hold at each posedge. busy stays 0; done never pulses. A mode change away from RUN clears gate_en at the next posedge.
  - IDLE, mode STEP, req = 1 at posedge k: load remaining = 1, gate_en <= ~hold, busy <= 1, go to ACTIVE.
  - IDLE, mode BURST, req = 1 at posedge k, burst_len = N > 0: load remaining = N, gate_en <= ~hold, busy <= 1, go to ACTIVE.
  - IDLE, mode BURST, burst_len = 0: no edges. done pulses at posedge k+1; busy stays 0.
  - ACTIVE, at each posedge where gate_en = 1: remaining decrements, since an edge was issued.
    - If remaining was 1: gate_en <= 0, busy <= 0, done <= 1 for one cycle, return to IDLE.
    - Otherwise: gate_en <= ~hold.
  - ACTIVE with gate_en = 0 (held): remaining is unchanged; gate_en <= ~hold.
- Resulting latency: an unheld burst of N yields gclk edges at posedges k+1 through k+N. done is high during cycle k+N, i.e. asserted after posedge k+N. busy falls at the same posedge.
- req is level-sampled; it is ignored while ACTIVE. req held high in STEP or BURST re-triggers on the posedge after done: one idle cycle, then the next accept.
- hold:
  - Asserted at posedge j, it blocks the edge at posedge j+1.
  - Deasserted at posedge j, it resumes edges at posedge j+1.
  - Pending counts are preserved; done is delayed by exactly the number of held cycles.
- Channels are fully independent; simultaneous requests on all channels are all accepted in the same cycle.
- Reset mid-burst abandons the burst. No done pulse is issued.

Decomposition:
- Shared package: mode encoding constants (MODE_OFF, MODE_RUN, MODE_STEP, MODE_BURST) and FSM state constants.
- One sub-module, clock_step_gate_chan: a single channel holding its FSM, counter, gate_en register, gating latch and output AND. The top level is a generate loop over CHANNELS plus port slicing.

Test Plan:
- Reset mid-high-phase of clk during a RUN-mode channel -> gclk drops to 0 immediately; busy = done = remaining = 0.
- Ch0 BURST, burst_len = 5, req pulse at posedge 10 -> gclk0 edges at posedges 11..15 only. remaining reads 5,4,3,2,1,0 after posedges 10..15. done0 high for one cycle after posedge 15.
- Ch1 STEP, req held high for 6 cycles -> one edge per accepted step, separated by a one-cycle gap. done1 pulses after each edge.
- Ch2 BURST, burst_len = 4, hold high for posedges 12..14 after accept at posedge 10 -> four edges total, at 11, 12, 16 and 17. done2 high for one cycle after posedge 17.
- BURST with burst_len = 0 -> no gclk edge; done pulses once; busy stays 0.
- All four channels in mixed modes, requests in the same cycle, and mode changed while busy -> each channel follows only its sampled mode. Edge counts per channel match requests exactly.
